ext_int_ctrl: RTL and testbench

EXT_INT_CTRL -- requirements
Module: ext_int_ctrl

---
 rtl/ext_int_ctrl.sv | 90 +++++++++
 tb/tb_ext_int_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - external interrupt gateway, priority arbiter and claim/complete handshake
// Sources are synchronised, latched into pending bits, arbitrated by priority and handed out by claim.
module ext_int_ctrl #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC-1:0]          src_in,
    input  logic [NSRC-1:0]          edge_mode,
    input  logic [NSRC-1:0]          src_en,
    input  logic [NSRC*PRIO_W-1:0]   prio,
    input  logic [PRIO_W-1:0]        threshold,
    input  logic                     claim_req,
    output logic                     claim_ack,
    output logic [4:0]               claim_id,
    input  logic                     complete_valid,
    input  logic [4:0]               complete_id,
    output logic [NSRC-1:0]          pending,
    output logic                     irq
);

    logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] infl_q, infl_d;
    logic [4:0]      id_q, id_d;
    logic            ack_q;
    logic [4:0]      cid_q;
    logic            irq_q;

    logic [NSRC-1:0]   trig;
    logic [NSRC-1:0]   claim_mask;
    logic [NSRC-1:0]   cmpl_mask;
    logic [4:0]        best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [PRIO_W-1:0] p;

    always_comb begin
        trig       = (edge_mode & sync2_q & ~sync3_q) | (~edge_mode & sync2_q);
        claim_mask = '0;
        cmpl_mask  = '0;
        best_id    = '0;
        best_prio  = '0;
        p          = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_mask[i] = claim_req && (id_q == 5'(i + 1));
            cmpl_mask[i]  = complete_valid && (complete_id == 5'(i + 1));
            p = prio[i*PRIO_W +: PRIO_W];
            // Strict compare keeps the lowest ID on priority ties; prio 0 never beats best_prio 0.
            if (pend_q[i] && src_en[i] && (p > threshold) && (p > best_prio)) begin
                best_prio = p;
                best_id   = 5'(i + 1);
            end
        end
        // A source being claimed this cycle must not be re-pended by a same-cycle trigger.
        pend_d = (pend_q | (trig & ~infl_q)) & ~claim_mask;
        infl_d = (infl_q & ~cmpl_mask) | claim_mask;
        id_d   = (claim_req && (id_q != 5'd0)) ? 5'd0 : best_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pend_q  <= '0;
            infl_q  <= '0;
            id_q    <= '0;
            ack_q   <= 1'b0;
            cid_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= src_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            infl_q  <= infl_d;
            id_q    <= id_d;
            ack_q   <= claim_req;
            cid_q   <= claim_req ? id_q : 5'd0;
            irq_q   <= (id_d != 5'd0);
        end
    end

    assign claim_ack = ack_q;
    assign claim_id  = cid_q;
    assign pending   = pend_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb/tb_ext_int_ctrl.sv - directed and randomized checks of ext_int_ctrl against a behavioural model
module tb_ext_int_ctrl;
    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        src_in, edge_mode, src_en;
    logic [NSRC*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]      threshold;
    logic                   claim_req, complete_valid;
    logic [4:0]             complete_id;
    logic                   claim_ack, irq;
    logic [4:0]             claim_id;
    logic [NSRC-1:0]        pending;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state; m_past[k] is the src_in vector seen k+1 edges ago.
    logic [NSRC-1:0] m_past [3];
    logic [NSRC-1:0] m_pend, m_infl;
    logic [4:0]      m_id, m_cid;
    logic            m_ack, m_irq;

    ext_int_ctrl #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk(clk), .rst(rst), .src_in(src_in), .edge_mode(edge_mode), .src_en(src_en),
        .prio(prio), .threshold(threshold), .claim_req(claim_req), .claim_ack(claim_ack),
        .claim_id(claim_id), .complete_valid(complete_valid), .complete_id(complete_id),
        .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PRIO_W-1:0] prio_of(input int id);
        logic [NSRC*PRIO_W-1:0] v;
        v = prio;
        return v[(id-1)*PRIO_W +: PRIO_W];
    endfunction

    // Highest eligible priority first, then the lowest ID holding it.
    function automatic logic [4:0] ref_arb(input logic [NSRC-1:0] pnd);
        int top;
        top = 0;
        for (int id = 1; id <= NSRC; id++)
            if (pnd[id-1] && src_en[id-1] && prio_of(id) > threshold && int'(prio_of(id)) > top)
                top = int'(prio_of(id));
        if (top != 0)
            for (int id = 1; id <= NSRC; id++)
                if (pnd[id-1] && src_en[id-1] && int'(prio_of(id)) == top && prio_of(id) > threshold)
                    return 5'(id);
        return 5'd0;
    endfunction

    task automatic model_edge();
        logic [NSRC-1:0] lvl, prv, np, ni;
        logic [4:0]      claimed;
        logic            t;
        int              c;
        if (rst) begin
            m_pend = '0; m_infl = '0; m_id = '0; m_cid = '0; m_ack = 1'b0; m_irq = 1'b0;
            for (int k = 0; k < 3; k++) m_past[k] = '0;
        end else begin
            lvl = m_past[1];
            prv = m_past[2];
            claimed = (claim_req && m_id != 5'd0) ? m_id : 5'd0;
            np = m_pend;
            ni = m_infl;
            for (int id = 1; id <= NSRC; id++) begin
                t = edge_mode[id-1] ? (lvl[id-1] && !prv[id-1]) : lvl[id-1];
                if (t && !m_infl[id-1]) np[id-1] = 1'b1;
                if (int'(claimed) == id) begin
                    np[id-1] = 1'b0;
                    ni[id-1] = 1'b1;
                end
            end
            c = int'(complete_id);
            if (complete_valid && c >= 1 && c <= NSRC && m_infl[c-1]) ni[c-1] = 1'b0;
            m_ack = claim_req;
            m_cid = claim_req ? m_id : 5'd0;
            m_id  = (claimed != 5'd0) ? 5'd0 : ref_arb(m_pend);
            m_irq = (m_id != 5'd0);
            m_pend = np;
            m_infl = ni;
            m_past[2] = m_past[1];
            m_past[1] = m_past[0];
            m_past[0] = src_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_irq", 32'(irq), 32'(m_irq));
        chk("model_ack", 32'(claim_ack), 32'(m_ack));
        if (m_ack) chk("model_claim_id", 32'(claim_id), 32'(m_cid));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_claim();
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
    endtask

    task automatic do_complete(input logic [4:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick();
        complete_valid = 1'b0;
        complete_id    = 5'd0;
    endtask

    task automatic set_prio(input int id, input logic [PRIO_W-1:0] v);
        prio[(id-1)*PRIO_W +: PRIO_W] = v;
    endtask

    initial begin
        rst = 1'b1; src_in = '0; edge_mode = '0; src_en = '1; prio = '0; threshold = '0;
        claim_req = 1'b0; complete_valid = 1'b0; complete_id = 5'd0;
        for (int k = 0; k < 3; k++) m_past[k] = '0;
        m_pend = '0; m_infl = '0; m_id = '0; m_cid = '0; m_ack = 1'b0; m_irq = 1'b0;
        ticks(2);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ack", 32'(claim_ack), 32'd0);
        rst = 1'b0;

        // Edge source ID 3: single-cycle pulse
        edge_mode[2] = 1'b1; set_prio(3, 3'd2);
        src_in[2] = 1'b1; tick();
        src_in[2] = 1'b0; tick();
        chk("e3_pend_early", 32'(pending[2]), 32'd0);
        tick();
        chk("e3_pend_E2", 32'(pending[2]), 32'd1);
        chk("e3_irq_E2", 32'(irq), 32'd0);
        tick();
        chk("e3_irq_E3", 32'(irq), 32'd1);
        do_claim();
        chk("e3_ack", 32'(claim_ack), 32'd1);
        chk("e3_claim_id", 32'(claim_id), 32'd3);
        chk("e3_pend_clr", 32'(pending[2]), 32'd0);
        chk("e3_irq_low", 32'(irq), 32'd0);
        do_complete(5'd3);
        tick();

        // Tie between IDs 2 and 5
        edge_mode[1] = 1'b1; edge_mode[4] = 1'b1; set_prio(2, 3'd4); set_prio(5, 3'd4);
        src_in[1] = 1'b1; src_in[4] = 1'b1; tick();
        src_in[1] = 1'b0; src_in[4] = 1'b0; ticks(3);
        chk("tie_irq", 32'(irq), 32'd1);
        do_claim();
        chk("tie_first", 32'(claim_id), 32'd2);
        tick();
        do_claim();
        chk("tie_second", 32'(claim_id), 32'd5);
        tick();
        do_claim();
        chk("tie_empty_ack", 32'(claim_ack), 32'd1);
        chk("tie_empty_id", 32'(claim_id), 32'd0);
        do_complete(5'd2);
        do_complete(5'd5);

        // Level source ID 1 held high
        edge_mode[0] = 1'b0; set_prio(1, 3'd1);
        src_in[0] = 1'b1; ticks(4);
        chk("lvl_irq", 32'(irq), 32'd1);
        do_claim();
        chk("lvl_claim_id", 32'(claim_id), 32'd1);
        src_in[0] = 1'b0; ticks(2);
        src_in[0] = 1'b1; ticks(4);
        chk("lvl_inflight_pend", 32'(pending[0]), 32'd0);
        chk("lvl_inflight_irq", 32'(irq), 32'd0);
        do_complete(5'd1);
        chk("lvl_pend_at_cmpl", 32'(pending[0]), 32'd0);
        tick();
        chk("lvl_repend", 32'(pending[0]), 32'd1);
        tick();
        chk("lvl_re_irq", 32'(irq), 32'd1);
        src_in[0] = 1'b0;
        do_claim();
        do_complete(5'd1);
        ticks(4);

        // Threshold gating on ID 4
        edge_mode[3] = 1'b1; set_prio(4, 3'd3); threshold = 3'd3;
        src_in[3] = 1'b1; tick();
        src_in[3] = 1'b0; ticks(3);
        chk("thr_pend", 32'(pending[3]), 32'd1);
        chk("thr_irq_blocked", 32'(irq), 32'd0);
        threshold = 3'd2; tick();
        chk("thr_irq_open", 32'(irq), 32'd1);

        // Ignored completions, then reset while in flight
        do_claim();
        chk("ign_claim_id", 32'(claim_id), 32'd4);
        do_complete(5'd0);
        do_complete(5'(NSRC + 1));
        do_complete(5'd2);
        chk("ign_pending", 32'(pending), 32'd0);
        src_in[3] = 1'b1; tick();
        src_in[3] = 1'b0; ticks(4);
        chk("ign_still_inflight", 32'(pending[3]), 32'd0);
        rst = 1'b1; claim_req = 1'b1; tick();
        chk("rst_mid_ack", 32'(claim_ack), 32'd0);
        chk("rst_mid_id", 32'(claim_id), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        chk("rst_mid_pend", 32'(pending), 32'd0);
        rst = 1'b0; claim_req = 1'b0;
        src_in[3] = 1'b1; tick();
        src_in[3] = 1'b0; ticks(3);
        chk("rst_freed_pend", 32'(pending[3]), 32'd1);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 60 == 0) begin
                edge_mode = NSRC'($urandom);
                prio      = (NSRC*PRIO_W)'($urandom);
                threshold = PRIO_W'($urandom_range(0, 2));
            end
            if (cyc % 25 == 0) src_en = NSRC'($urandom);
            src_in         = NSRC'($urandom);
            claim_req      = ($urandom_range(0, 3) == 0);
            complete_valid = ($urandom_range(0, 2) == 0);
            complete_id    = 5'($urandom_range(0, NSRC + 2));
            rst            = (cyc == 300);
            tick();
        end
        rst = 1'b0; claim_req = 1'b0; complete_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
